// File: rtl/forward_ctrl_pkg.sv
// Shared pipeline definitions: operand-mux forward codes and the per-stage
// destination tag carried through EX/MEM and MEM/WB.
package forward_ctrl_pkg;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_MEMDI = 2'b11;

  localparam int REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
    logic             jmp;
  } tag_t;

  // A stage can only supply an operand the EX instruction really reads;
  // x0 is hardwired zero so it never forwards.
  function automatic logic tag_hit(input tag_t t, input logic [REG_W-1:0] rs,
                                   input logic use_rs, input logic ex_valid);
    return t.valid & t.we & (t.rd != '0) & (t.rd == rs) & use_rs & ex_valid;
  endfunction

endpackage

// File: rtl/forward_ctrl_fwd_match.sv
// Per-operand forward selection: picks the youngest matching producer and
// reports a load-use hazard when the producer's data is not yet available.
module fwd_match
  import forward_ctrl_pkg::*;
#(
  parameter bit LOAD_STALL = 1'b0
) (
  input  logic             i_ex_valid,
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_use_rs,
  input  tag_t             i_exmem,
  input  tag_t             i_memwb,
  output logic [1:0]       o_code,
  output logic             o_jmp,
  output logic             o_stall
);

  logic w_hit_exmem;
  logic w_hit_memwb;
  logic w_unused;

  assign w_hit_exmem = tag_hit(i_exmem, i_rs, i_use_rs, i_ex_valid);
  assign w_hit_memwb = tag_hit(i_memwb, i_rs, i_use_rs, i_ex_valid);
  // By MEM/WB a load's data and a jump's link value are already in the result.
  assign w_unused    = i_memwb.ld ^ i_memwb.jmp;

  always_comb begin
    o_code  = FWD_NONE;
    o_jmp   = 1'b0;
    o_stall = 1'b0;
    if (w_hit_exmem) begin
      if (i_exmem.ld) begin
        if (LOAD_STALL) o_stall = 1'b1;
        else            o_code  = FWD_MEMDI;
      end else begin
        o_code = FWD_EXMEM;
        o_jmp  = i_exmem.jmp;
      end
    end else if (w_hit_memwb) begin
      o_code = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding control: tracks destination tags of the two instructions ahead
// of EX and drives operand mux selects, load-use stall and an event counter.
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter bit LOAD_STALL = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EX_VALID,
  input  logic             FLUSH,
  input  logic [REG_W-1:0] EX_RS1,
  input  logic [REG_W-1:0] EX_RS2,
  input  logic             EX_USE_RS1,
  input  logic             EX_USE_RS2,
  input  logic [REG_W-1:0] EX_RD,
  input  logic             EX_WE,
  input  logic             EX_LD,
  input  logic             EX_JMP,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             JMP_A,
  output logic             JMP_B,
  output logic             STALL,
  output logic [CNT_W-1:0] FWD_CNT
);

  tag_t             r_exmem;
  tag_t             r_memwb;
  logic [CNT_W-1:0] r_cnt;

  logic             w_stall_a;
  logic             w_stall_b;
  logic             w_stall;
  logic             w_any_fwd;

  fwd_match #(.LOAD_STALL(LOAD_STALL)) u_match_a (
    .i_ex_valid (EX_VALID),
    .i_rs       (EX_RS1),
    .i_use_rs   (EX_USE_RS1),
    .i_exmem    (r_exmem),
    .i_memwb    (r_memwb),
    .o_code     (FWD_A),
    .o_jmp      (JMP_A),
    .o_stall    (w_stall_a)
  );

  fwd_match #(.LOAD_STALL(LOAD_STALL)) u_match_b (
    .i_ex_valid (EX_VALID),
    .i_rs       (EX_RS2),
    .i_use_rs   (EX_USE_RS2),
    .i_exmem    (r_exmem),
    .i_memwb    (r_memwb),
    .o_code     (FWD_B),
    .o_jmp      (JMP_B),
    .o_stall    (w_stall_b)
  );

  assign w_stall   = w_stall_a | w_stall_b;
  assign w_any_fwd = (FWD_A != FWD_NONE) | (FWD_B != FWD_NONE);
  assign STALL     = w_stall;
  assign FWD_CNT   = r_cnt;

  // A stalled or flushed EX instruction enters EX/MEM as a bubble; the
  // stalled one is re-presented next cycle by the upstream pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_exmem <= '0;
      r_memwb <= '0;
      r_cnt   <= '0;
    end else begin
      r_exmem.valid <= EX_VALID & ~FLUSH & ~w_stall;
      r_exmem.rd    <= EX_RD;
      r_exmem.we    <= EX_WE;
      r_exmem.ld    <= EX_LD;
      r_exmem.jmp   <= EX_JMP;
      r_memwb       <= r_exmem;
      if (w_any_fwd && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench: two instances (forwarded load / stalled load) share one
// directed stimulus stream; a negedge monitor checks each queued expectation.
module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ex_valid = 1'b0, flush = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       use1 = 1'b0, use2 = 1'b0, we = 1'b0, ld = 1'b0, jmp = 1'b0;

  logic [1:0] fa0, fb0, fa1, fb1;
  logic       ja0, jb0, st0, ja1, jb1, st1;
  logic [3:0] cnt0, cnt1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         idx;
    logic [6:0] e0;
    logic [6:0] e1;
    logic [3:0] c0;
    logic [3:0] c1;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  forward_ctrl #(.LOAD_STALL(1'b0), .CNT_W(4)) dut0 (
    .CLK(clk), .RST(rst), .EX_VALID(ex_valid), .FLUSH(flush),
    .EX_RS1(rs1), .EX_RS2(rs2), .EX_USE_RS1(use1), .EX_USE_RS2(use2),
    .EX_RD(rd), .EX_WE(we), .EX_LD(ld), .EX_JMP(jmp),
    .FWD_A(fa0), .FWD_B(fb0), .JMP_A(ja0), .JMP_B(jb0), .STALL(st0), .FWD_CNT(cnt0)
  );

  forward_ctrl #(.LOAD_STALL(1'b1), .CNT_W(4)) dut1 (
    .CLK(clk), .RST(rst), .EX_VALID(ex_valid), .FLUSH(flush),
    .EX_RS1(rs1), .EX_RS2(rs2), .EX_USE_RS1(use1), .EX_USE_RS2(use2),
    .EX_RD(rd), .EX_WE(we), .EX_LD(ld), .EX_JMP(jmp),
    .FWD_A(fa1), .FWD_B(fb1), .JMP_A(ja1), .JMP_B(jb1), .STALL(st1), .FWD_CNT(cnt1)
  );

  // {FWD_A, JMP_A, FWD_B, JMP_B, STALL}
  function automatic logic [6:0] e(input logic [1:0] fa, input logic ja,
                                   input logic [1:0] fb, input logic jb, input logic st);
    return {fa, ja, fb, jb, st};
  endfunction

  int vec = 0;

  task automatic step(input logic r, input logic v, input logic fl,
                      input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub,
                      input logic [4:0] d, input logic w, input logic l, input logic j,
                      input logic [6:0] e0, input logic [6:0] e1,
                      input logic [3:0] c0, input logic [3:0] c1);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; ex_valid = v; flush = fl;
    rs1 = a; use1 = ua; rs2 = b; use2 = ub;
    rd = d; we = w; ld = l; jmp = j;
    x.idx = vec; x.e0 = e0; x.e1 = e1; x.c0 = c0; x.c1 = c1;
    sb.push_back(x);
    vec++;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        checks++;
        if ({fa0, ja0, fb0, jb0, st0} !== x.e0) begin
          failures++;
          $display("FAIL v%0d ctrl_ls0 got=%b want=%b", x.idx, {fa0, ja0, fb0, jb0, st0}, x.e0);
        end
        checks++;
        if ({fa1, ja1, fb1, jb1, st1} !== x.e1) begin
          failures++;
          $display("FAIL v%0d ctrl_ls1 got=%b want=%b", x.idx, {fa1, ja1, fb1, jb1, st1}, x.e1);
        end
        checks++;
        if (cnt0 !== x.c0) begin
          failures++;
          $display("FAIL v%0d cnt_ls0 got=%0d want=%0d", x.idx, cnt0, x.c0);
        end
        checks++;
        if (cnt1 !== x.c1) begin
          failures++;
          $display("FAIL v%0d cnt_ls1 got=%0d want=%0d", x.idx, cnt1, x.c1);
        end
      end
    end
  end

  initial begin : driver
    logic [6:0] z;
    logic [3:0] c;
    z = '0;
    //    rst v fl rs1 u1 rs2 u2 rd  we ld jmp  exp_ls0                 exp_ls1                 c0 c1
    step(1, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   z,                      z,                      0, 0); // reset
    step(0, 1, 0, 0,  0, 0,  0, 5,  1, 0, 0,   z,                      z,                      0, 0); // ADD x5
    step(0, 1, 0, 5,  1, 0,  0, 0,  0, 0, 0,   e(2'b01,0,2'b00,0,0),   e(2'b01,0,2'b00,0,0),   0, 0);
    step(0, 1, 0, 0,  0, 5,  1, 0,  0, 0, 0,   e(2'b00,0,2'b10,0,0),   e(2'b00,0,2'b10,0,0),   1, 1);
    step(0, 1, 0, 0,  0, 0,  0, 1,  1, 0, 1,   z,                      z,                      2, 2); // JAL x1
    step(0, 1, 0, 1,  1, 0,  0, 0,  0, 0, 0,   e(2'b01,1,2'b00,0,0),   e(2'b01,1,2'b00,0,0),   2, 2);
    step(0, 1, 0, 0,  0, 0,  0, 7,  1, 1, 0,   z,                      z,                      3, 3); // LW x7
    step(0, 1, 0, 7,  1, 0,  0, 0,  0, 0, 0,   e(2'b11,0,2'b00,0,0),   e(2'b00,0,2'b00,0,1),   3, 3);
    step(0, 1, 0, 7,  1, 0,  0, 0,  0, 0, 0,   e(2'b10,0,2'b00,0,0),   e(2'b10,0,2'b00,0,0),   4, 3);
    step(0, 1, 0, 0,  0, 0,  0, 3,  1, 0, 0,   z,                      z,                      5, 4); // x3 older
    step(0, 1, 0, 0,  0, 0,  0, 3,  1, 0, 0,   z,                      z,                      5, 4); // x3 younger
    step(0, 1, 0, 3,  1, 3,  1, 0,  0, 0, 0,   e(2'b01,0,2'b01,0,0),   e(2'b01,0,2'b01,0,0),   5, 4);
    step(0, 1, 0, 0,  0, 0,  0, 0,  1, 0, 0,   z,                      z,                      6, 5); // write x0
    step(0, 1, 0, 0,  1, 0,  0, 0,  0, 0, 0,   z,                      z,                      6, 5);
    step(0, 1, 1, 0,  0, 0,  0, 4,  1, 0, 0,   z,                      z,                      6, 5); // flushed x4
    step(0, 1, 0, 4,  1, 0,  0, 0,  0, 0, 0,   z,                      z,                      6, 5);
    step(0, 1, 0, 0,  0, 0,  0, 8,  1, 1, 0,   z,                      z,                      6, 5); // LW x8
    step(0, 1, 1, 8,  1, 0,  0, 0,  0, 0, 0,   e(2'b11,0,2'b00,0,0),   e(2'b00,0,2'b00,0,1),   6, 5); // flush+stall
    step(0, 1, 0, 8,  1, 0,  0, 0,  0, 0, 0,   e(2'b10,0,2'b00,0,0),   e(2'b10,0,2'b00,0,0),   7, 5);
    step(0, 1, 0, 0,  0, 0,  0, 9,  1, 1, 0,   z,                      z,                      8, 6); // LW x9
    step(1, 1, 0, 9,  1, 0,  0, 0,  0, 0, 0,   e(2'b11,0,2'b00,0,0),   e(2'b00,0,2'b00,0,1),   8, 6); // reset in stall
    step(0, 1, 0, 9,  1, 0,  0, 0,  0, 0, 0,   z,                      z,                      0, 0);
    step(0, 1, 0, 0,  0, 0,  0, 10, 1, 0, 0,   z,                      z,                      0, 0); // ADD x10
    for (int i = 0; i < 19; i++) begin
      c = (i > 15) ? 4'd15 : 4'(i);
      step(0, 1, 0, 10, 1, 0, 0, 10, 1, 0, 0, e(2'b01,0,2'b00,0,0), e(2'b01,0,2'b00,0,0), c, c);
    end
    step(0, 0, 0, 10, 1, 0,  0, 0,  0, 0, 0,   z,                      z,                      15, 15);
    step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,   z,                      z,                      15, 15);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL, default 0: 0 = load-use resolved by forwarding memory read data (code 2'b11); 1 = load-use resolved by one-cycle stall.
REQ-002 SHALL have parameter CNT_W, default 16: width of the forwarding event counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports, one per line, as name  direction  width  meaning:
  CLK  in  1  clock, all state updates on rising edge
  RST  in  1  synchronous active-high reset
  EX_VALID  in  1  instruction in EX stage is valid
  FLUSH  in  1  squash EX instruction (e.g. taken branch)
  EX_RS1, EX_RS2  in  5 each  source register indices of EX instruction
  EX_USE_RS1, EX_USE_RS2  in  1 each  EX instruction reads that source
  EX_RD  in  5  destination of EX instruction
  EX_WE  in  1  EX instruction writes register file
  EX_LD  in  1  EX instruction is a load
  EX_JMP  in  1  EX instruction is JAL/JALR (writes PC+4)
  FWD_A, FWD_B  out  2 each  operand mux select: 00 none, 01 EX/MEM, 10 MEM/WB, 11 memory read data
  JMP_A, JMP_B  out  1 each  with code 01: forward PC+4 instead of ALU result
  STALL  out  1  hold EX instruction one cycle (LOAD_STALL=1 only)
  FWD_CNT  out  CNT_W  saturating count of cycles with any non-00 forward

Function
REQ-005 SHALL hold two tag stages, EX/MEM and MEM/WB, each {valid, rd, we, ld, jmp}.
REQ-006 SHALL load EX/MEM each cycle from the EX_* inputs with valid = EX_VALID & ~FLUSH & ~STALL; when STALL=1, EX/MEM becomes a bubble (valid=0).
REQ-007 SHALL copy EX/MEM into MEM/WB every cycle, unconditionally.
REQ-008 A stage SHALL match operand X when stage valid, we=1, rd!=0, rd==EX_RSX and EX_USE_RSX=1 and EX_VALID=1.
REQ-009 FWD_X SHALL be combinational (zero latency) from EX inputs and the tag registers.
REQ-010 Priority for FWD_X: EX/MEM match over MEM/WB match over none.
REQ-011 EX/MEM match with ld=0 SHALL give 01, with JMP_X = EX/MEM.jmp.
REQ-012 EX/MEM match with ld=1: LOAD_STALL=0 gives 11; LOAD_STALL=1 gives 00 with STALL=1.
REQ-013 MEM/WB match (no EX/MEM match) SHALL give 10, JMP_X=0.
REQ-014 JMP_X SHALL be 0 whenever FWD_X != 01.
REQ-015 STALL SHALL be asserted for exactly one cycle per load-use; the next cycle the load sits in MEM/WB and forwarding gives 10.
REQ-016 If FLUSH=1 while a STALL condition is present, STALL SHALL still be driven, but EX/MEM captures a bubble.
REQ-017 Rd=0 writes SHALL never forward; outputs for the operand SHALL be 00.
REQ-018 FWD_CNT SHALL increment by 1 in a cycle where FWD_A!=00 or FWD_B!=00 and SHALL saturate at all-ones.

Reset
REQ-019 RST=1 at a rising edge SHALL clear both tag stages' valid bits and FWD_CNT to 0.
REQ-020 During and after reset, FWD_A/FWD_B SHALL be 00, JMP_A/JMP_B 0 and STALL 0 until a valid producer enters EX/MEM.
REQ-021 Reset asserted during a stall cycle SHALL drop STALL on the following cycle and discard the pending load tag.

Structure
REQ-022 Forward codes (NONE, EXMEM, MEMWB, MEMDI) SHALL be constants in the shared pipeline package, which the operand mux also uses.
REQ-023 The tag-stage record SHALL be a typedef in that package.
REQ-024 One sub-module, fwd_match, SHALL compute per-operand code/jump from the two stages; it is instantiated twice (A, B).

Verification
REQ-025 Producer ADD rd=5 followed by consumer rs1=5 -> FWD_A=01, JMP_A=0; one cycle later a consumer rs2=5 -> FWD_B=10.
REQ-026 JAL rd=1 followed by consumer rs1=1 -> FWD_A=01, JMP_A=1.
REQ-027 LW rd=7 followed by consumer rs1=7: LOAD_STALL=0 -> FWD_A=11, STALL=0; LOAD_STALL=1 -> cycle 0: STALL=1, FWD_A=00; cycle 1: FWD_A=10, STALL=0.
REQ-028 Both stages write rd=3 (older in MEM/WB), consumer rs1=rs2=3 -> FWD_A=FWD_B=01; producer rd=0 followed by consumer rs1=0 -> 00.
REQ-029 Producer rd=4 with FLUSH=1, next consumer rs1=4 -> FWD_A=00; RST mid-stream -> all outputs 00, FWD_CNT=0.
REQ-030 Forward on 2^CNT_W+3 consecutive cycles with CNT_W=4 -> FWD_CNT holds at 15.
